// File: rtl/codificador_pkg.sv
// Shared definitions for the Codificador arbiter: defaults, FSM state encoding and
// the settle-counter width helper.
package codificador_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int SETTLE_DEF = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_ABORT   = 3'd5;

  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction
endpackage

// File: rtl/codificador_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);
  logic [IW:0] pos;
  logic        found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = 0; off < NREQ; off++) begin
      pos = {1'b0, pointer} + (IW+1)'(off);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (!found && req[pos[IW-1:0]]) begin
        found                 = 1'b1;
        grant[pos[IW-1:0]]    = 1'b1;
        index                 = pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/codificador_arbiter.sv
// Shares one Codificador among NREQ requesters: round-robin grant, load, settle with
// Ready held, capture the encoder output and return it with a single-cycle Ack.
module codificador_arbiter
  import codificador_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ*DATA_W-1:0] ReqData,
  output logic [NREQ-1:0]        Grant,
  output logic                   Ack,
  output logic [DATA_W-1:0]      ResultData,
  output logic                   Busy,
  output logic [DATA_W-1:0]      EncInput,
  output logic                   EncReady,
  output logic                   EncReset,
  input  logic [DATA_W-1:0]      EncOutput
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(SETTLE_CYCLES);

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   own_idx;
  logic [IW-1:0]   next_ptr;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            owner_req;
  logic            drop;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (Req),
    .pointer (ptr),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  assign owner_req = |(Req & Grant);
  assign next_ptr  = (own_idx == IW'(NREQ-1)) ? '0 : own_idx + 1'b1;
  // Owner withdrawing before the result is captured abandons the operation.
  assign drop      = (state == ST_LOAD || state == ST_SETTLE || state == ST_CAPTURE) && !owner_req;

  assign Ack      = (state == ST_ACK);
  assign Busy     = (state != ST_IDLE);
  assign EncReady = (state == ST_SETTLE) || (state == ST_CAPTURE);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      own_idx    <= '0;
      Grant      <= '0;
      ResultData <= '0;
      EncInput   <= '0;
      EncReset   <= 1'b1;
    end else begin
      EncReset <= 1'b0;
      if (drop) begin
        state    <= ST_ABORT;
        Grant    <= '0;
        EncReset <= 1'b1;
        ptr      <= next_ptr;
      end else begin
        case (state)
          ST_IDLE: if (|Req) begin
            Grant    <= arb_grant;
            own_idx  <= arb_idx;
            EncInput <= ReqData[int'(arb_idx)*DATA_W +: DATA_W];
            state    <= ST_LOAD;
          end
          ST_LOAD: begin
            cnt   <= CW'(SETTLE_CYCLES - 1);
            state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (cnt == '0) state <= ST_CAPTURE;
            else           cnt   <= cnt - 1'b1;
          end
          ST_CAPTURE: begin
            ResultData <= EncOutput;
            state      <= ST_ACK;
          end
          ST_ACK: begin
            Grant <= '0;
            ptr   <= next_ptr;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
